prog_memory_ctrl: RTL

Parametrised instruction memory with a built-in clear engine, a streaming program loader and a registered read port with valid flag. Supersedes the single-port write-first program RAM: adds a selectable write/read collision mode, a valid/ready load channel with auto-increment addressing, and out-of-range detection. Sits between the program loader/testbench and the instruction fetch stage.

---
 rtl/prog_memory_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/prog_memory_ctrl.sv
// Instruction RAM with power-on clear engine, valid/ready streaming loader and registered read port.
// Read latency 1 cycle; loader ready only in LOAD, direct writes only in IDLE.
module prog_memory_ctrl #(
  parameter int INSTR_LEN = 20,
  parameter int DEPTH     = 100,
  parameter int ADDR      = 7,
  parameter int RD_MODE   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR-1:0]      wr_addr,
  input  logic [INSTR_LEN-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDR-1:0]      rd_addr,
  output logic [INSTR_LEN-1:0] rd_data,
  output logic                 rd_valid,
  input  logic                 ld_start,
  input  logic [ADDR-1:0]      ld_base,
  input  logic                 ld_valid,
  input  logic [INSTR_LEN-1:0] ld_data,
  input  logic                 ld_last,
  output logic                 ld_ready,
  output logic                 ld_done,
  output logic [ADDR:0]        ld_count,
  output logic                 busy,
  output logic                 addr_err
);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  localparam logic [ADDR:0]   DEPTH_C = (ADDR+1)'(DEPTH);
  localparam logic [ADDR-1:0] LAST_C  = ADDR'(DEPTH - 1);

  logic [INSTR_LEN-1:0] mem [DEPTH];

  state_t               state_q, state_d;
  logic [ADDR-1:0]      clr_ptr_q, clr_ptr_d;
  logic [ADDR-1:0]      ld_ptr_q, ld_ptr_d;
  logic [ADDR:0]        ld_count_q, ld_count_d;
  logic [INSTR_LEN-1:0] rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 ld_done_q, ld_done_d;
  logic                 addr_err_q, addr_err_d;

  logic                 we;
  logic [ADDR-1:0]      waddr;
  logic [INSTR_LEN-1:0] wdata;
  logic                 rd_hit, rd_oob, wr_oob, base_oob, ld_acc;

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    ld_ptr_d   = ld_ptr_q;
    ld_count_d = ld_count_q;
    ld_done_d  = 1'b0;
    we         = 1'b0;
    waddr      = '0;
    wdata      = '0;
    wr_oob     = ({1'b0, wr_addr} >= DEPTH_C);
    rd_oob     = ({1'b0, rd_addr} >= DEPTH_C);
    base_oob   = ({1'b0, ld_base} >= DEPTH_C);
    ld_acc     = 1'b0;
    rd_hit     = 1'b0;
    addr_err_d = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        we        = 1'b1;
        waddr     = clr_ptr_q;
        clr_ptr_d = clr_ptr_q + ADDR'(1);
        if (clr_ptr_q == LAST_C) begin
          clr_ptr_d = '0;
          state_d   = ST_IDLE;
        end
      end
      ST_IDLE: begin
        rd_hit     = rd_en;
        we         = wr_en && !wr_oob;
        waddr      = wr_addr;
        wdata      = wr_data;
        addr_err_d = (wr_en && wr_oob) || (ld_start && base_oob);
        if (ld_start) begin
          ld_count_d = '0;
          ld_ptr_d   = ld_base;
          // A bad base never enters LOAD; the caller still gets a done pulse.
          if (base_oob) ld_done_d = 1'b1;
          else          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        rd_hit = rd_en;
        ld_acc = ld_valid;
        we     = ld_acc;
        waddr  = ld_ptr_q;
        wdata  = ld_data;
        if (ld_acc) begin
          ld_ptr_d   = ld_ptr_q + ADDR'(1);
          ld_count_d = ld_count_q + (ADDR+1)'(1);
          if (ld_last || ld_ptr_q == LAST_C) begin
            ld_done_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase

    rd_valid_d = rd_hit;
    rd_data_d  = rd_data_q;
    if (rd_hit) begin
      addr_err_d = addr_err_d || rd_oob;
      if (rd_oob)
        rd_data_d = '0;
      else if (RD_MODE == 0 && we && waddr == rd_addr)
        rd_data_d = wdata;
      else
        rd_data_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_CLEAR;
      clr_ptr_q  <= '0;
      ld_ptr_q   <= '0;
      ld_count_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ld_done_q  <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      ld_ptr_q   <= ld_ptr_d;
      ld_count_q <= ld_count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ld_done_q  <= ld_done_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign ld_ready = (state_q == ST_LOAD);
  assign ld_done  = ld_done_q;
  assign ld_count = ld_count_q;
  assign busy     = (state_q != ST_IDLE);
  assign addr_err = addr_err_q;

endmodule
